// File: rtl/craps_datapath_if.sv
// Roll/sp command and dice/status bus between the craps Controller and its datapath.
// CRAPS_ROLL_COUNT_EN adds the saturating roll_count field.
interface craps_datapath_if;
  logic       roll;
  logic       sp;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic [3:0] point;
  logic       sum_valid;
  logic       seven_out;
  logic       natural;
  logic       craps;
  logic       eq;
`ifdef CRAPS_ROLL_COUNT_EN
  logic [7:0] roll_count;

  modport master (
    output roll, sp,
    input  die1, die2, sum, point, sum_valid, seven_out, natural, craps, eq, roll_count
  );

  modport slave (
    input  roll, sp,
    output die1, die2, sum, point, sum_valid, seven_out, natural, craps, eq, roll_count
  );
`else
  modport master (
    output roll, sp,
    input  die1, die2, sum, point, sum_valid, seven_out, natural, craps, eq
  );

  modport slave (
    input  roll, sp,
    output die1, die2, sum, point, sum_valid, seven_out, natural, craps, eq
  );
`endif
endinterface

// File: rtl/craps_datapath.sv
// Craps datapath: free-running dice counters, roll capture, sum/point registers, status flags.
// Optional CRAPS_ROLL_COUNT_EN adds an 8-bit saturating capture counter.
module craps_datapath #(
  parameter int unsigned FACES     = 6,
  parameter int unsigned DIE1_INIT = 1,
  parameter int unsigned DIE2_INIT = 1
) (
  input logic             clk_main,
  input logic             reset,
  craps_datapath_if.slave bus
);

  localparam int unsigned DIE_W = 3;
  localparam int unsigned SUM_W = 4;
  localparam logic [DIE_W-1:0] FACE_MAX  = DIE_W'(FACES);
  localparam logic [DIE_W-1:0] FACE_MIN  = DIE_W'(1);
  localparam logic [DIE_W-1:0] CNT1_RST  = DIE_W'(DIE1_INIT);
  localparam logic [DIE_W-1:0] CNT2_RST  = DIE_W'(DIE2_INIT);

  logic [DIE_W-1:0] cnt1_q, cnt1_d;
  logic [DIE_W-1:0] cnt2_q, cnt2_d;
  logic             roll_q, roll_d;
  logic             sp_q, sp_d;
  logic [DIE_W-1:0] die1_q, die1_d;
  logic [DIE_W-1:0] die2_q, die2_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] point_q, point_d;
  logic             sum_valid_q, sum_valid_d;
  logic             point_valid_q, point_valid_d;

  logic rise_roll_c;
  logic rise_sp_c;
  logic cnt1_wrap_c;

`ifdef CRAPS_ROLL_COUNT_EN
  localparam int unsigned RC_W = 8;
  localparam logic [RC_W-1:0] RC_MAX = {RC_W{1'b1}};
  logic [RC_W-1:0] roll_count_q, roll_count_d;
`endif

  // Next-state: counters, edge detectors, capture and point store
  always_comb begin
    cnt1_d        = cnt1_q;
    cnt2_d        = cnt2_q;
    roll_d        = bus.roll;
    sp_d          = bus.sp;
    die1_d        = die1_q;
    die2_d        = die2_q;
    sum_d         = sum_q;
    point_d       = point_q;
    sum_valid_d   = sum_valid_q;
    point_valid_d = point_valid_q;

    rise_roll_c = bus.roll & ~roll_q;
    rise_sp_c   = bus.sp & ~sp_q;
    cnt1_wrap_c = (cnt1_q == FACE_MAX);

    cnt1_d = cnt1_wrap_c ? FACE_MIN : cnt1_q + DIE_W'(1);
    if (cnt1_wrap_c) begin
      cnt2_d = (cnt2_q == FACE_MAX) ? FACE_MIN : cnt2_q + DIE_W'(1);
    end

    // Captures take the pre-increment counter values
    if (rise_roll_c) begin
      die1_d      = cnt1_q;
      die2_d      = cnt2_q;
      sum_d       = SUM_W'(cnt1_q) + SUM_W'(cnt2_q);
      sum_valid_d = 1'b1;
    end

    // Point takes the registered sum, so a coincident roll leaves it the old value
    if (rise_sp_c) begin
      point_d       = sum_q;
      point_valid_d = 1'b1;
    end
  end

`ifdef CRAPS_ROLL_COUNT_EN
  always_comb begin
    roll_count_d = roll_count_q;
    if (rise_roll_c && (roll_count_q != RC_MAX)) begin
      roll_count_d = roll_count_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      roll_count_q <= '0;
    end else begin
      roll_count_q <= roll_count_d;
    end
  end

  assign bus.roll_count = roll_count_q;
`endif

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      cnt1_q        <= CNT1_RST;
      cnt2_q        <= CNT2_RST;
      roll_q        <= 1'b0;
      sp_q          <= 1'b0;
      die1_q        <= '0;
      die2_q        <= '0;
      sum_q         <= '0;
      point_q       <= '0;
      sum_valid_q   <= 1'b0;
      point_valid_q <= 1'b0;
    end else begin
      cnt1_q        <= cnt1_d;
      cnt2_q        <= cnt2_d;
      roll_q        <= roll_d;
      sp_q          <= sp_d;
      die1_q        <= die1_d;
      die2_q        <= die2_d;
      sum_q         <= sum_d;
      point_q       <= point_d;
      sum_valid_q   <= sum_valid_d;
      point_valid_q <= point_valid_d;
    end
  end

  // Status decode straight off the registers; silent until a roll exists
  always_comb begin
    bus.seven_out = 1'b0;
    bus.natural   = 1'b0;
    bus.craps     = 1'b0;
    bus.eq        = 1'b0;
    if (sum_valid_q) begin
      bus.seven_out = (sum_q == SUM_W'(7));
      bus.natural   = (sum_q == SUM_W'(7)) || (sum_q == SUM_W'(11));
      bus.craps     = (sum_q == SUM_W'(2)) || (sum_q == SUM_W'(3)) || (sum_q == SUM_W'(12));
      bus.eq        = point_valid_q && (sum_q == point_q);
    end
  end

  assign bus.die1      = die1_q;
  assign bus.die2      = die2_q;
  assign bus.sum       = sum_q;
  assign bus.point     = point_q;
  assign bus.sum_valid = sum_valid_q;

endmodule
